// File: rtl/fft_pkg.sv
// Shared constants for the radix-4 FFT stage: twiddle leg mapping, unity ROM address,
// frame length and sequencer state encodings.
package fft_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned IDX_W     = 4;

  localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(FRAME_LEN - 1);
  localparam logic [3:0]       ROM_UNITY_ADDR = 4'b1100;

  // Leg select m -> ROM address bits [3:2]; entry 0 is the lowest slice.
  localparam logic [3:0][1:0] LEG_MAP = {2'b10, 2'b00, 2'b01, 2'b11};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fft_twiddle_addr_gen.sv
// Maps a sample index within a 16-point frame to its radix-4 twiddle ROM address.
module fft_twiddle_addr_gen
  import fft_pkg::*;
(
  input  logic [3:0] idx,
  input  logic       bypass,
  output logic [3:0] addr_c
);

  // idx[3:2] selects the leg, idx[1:0] the position within it.
  always_comb begin
    addr_c = {LEG_MAP[idx[3:2]], idx[1:0]};
    if (bypass) begin
      addr_c = ROM_UNITY_ADDR;
    end
  end

endmodule

// File: rtl/fft_r4_twiddle_sequencer.sv
// Walks one 16-sample frame through the twiddle ROM, presenting each sample together with
// its twiddle one clock after acceptance; counts delivered frames and flags stray starts.
module fft_r4_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cfg_bypass,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_re,
  input  logic [DATA_WIDTH-1:0]      in_im,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_re,
  output logic [DATA_WIDTH-1:0]      out_im,
  output logic [3:0]                 out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frames_done,
  output logic                       overrun
);

  logic [1:0]                 state, state_d;
  logic [3:0]                 cnt, cnt_d;
  logic                       bypass, bypass_d;
  logic [ADDR_WIDTH-1:0]      addr_hold;
  logic [3:0]                 twiddle_addr;
  logic                       accept, pop;

  logic                       out_valid_d, out_last_d, busy_d, overrun_d;
  logic [DATA_WIDTH-1:0]      out_re_d, out_im_d;
  logic [3:0]                 out_idx_d;
  logic [FRAME_CNT_WIDTH-1:0] frames_done_d;

  fft_twiddle_addr_gen u_addr_gen (
    .idx    (cnt),
    .bypass (bypass),
    .addr_c (twiddle_addr)
  );

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // The ROM registers its address every edge, so replaying the last address keeps its data still.
  assign rom_addr = accept ? ADDR_WIDTH'(twiddle_addr) : addr_hold;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bypass_d      = bypass;
    out_valid_d   = out_valid;
    out_re_d      = out_re;
    out_im_d      = out_im;
    out_idx_d     = out_idx;
    out_last_d    = out_last;
    overrun_d     = overrun;
    frames_done_d = frames_done;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          bypass_d = cfg_bypass;
        end
      end
      ST_RUN: begin
        if (start) overrun_d = 1'b1;
        if (accept && (cnt == LAST_IDX)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (start) overrun_d = 1'b1;
        if (pop && out_last) begin
          state_d       = ST_IDLE;
          frames_done_d = frames_done + FRAME_CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop and an accept in the same cycle simply reload the output slot.
    if (accept) begin
      out_valid_d = 1'b1;
      out_re_d    = in_re;
      out_im_d    = in_im;
      out_idx_d   = cnt;
      out_last_d  = (cnt == LAST_IDX);
      cnt_d       = cnt + 4'd1;
    end else if (pop) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bypass      <= 1'b0;
      addr_hold   <= ADDR_WIDTH'(ROM_UNITY_ADDR);
      out_valid   <= 1'b0;
      out_re      <= '0;
      out_im      <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      frames_done <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bypass      <= bypass_d;
      addr_hold   <= rom_addr;
      out_valid   <= out_valid_d;
      out_re      <= out_re_d;
      out_im      <= out_im_d;
      out_idx     <= out_idx_d;
      out_last    <= out_last_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      frames_done <= frames_done_d;
    end
  end

endmodule

// File: tb/tb_fft_r4_twiddle_sequencer.sv
// Directed and randomised checks of the twiddle sequencer against a behavioural twiddle ROM.
module tb_fft_r4_twiddle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_bypass, in_valid, in_ready, out_valid, out_ready;
  logic        out_last, busy, overrun;
  logic [15:0] in_re, in_im, out_re, out_im, frames_done;
  logic [3:0]  rom_addr, out_idx;
  logic [15:0] datar, datai;
  logic [15:0] rom_re [16];
  logic [15:0] rom_im [16];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] tw_re;
    logic [15:0] tw_im;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  fft_r4_twiddle_sequencer #(
    .DATA_WIDTH      (16),
    .ADDR_WIDTH      (4),
    .FRAME_CNT_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_bypass  (cfg_bypass),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .rom_addr    (rom_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy),
    .frames_done (frames_done),
    .overrun     (overrun)
  );

  // Twiddle ROM with a registered address, as seen by the parent.
  always @(posedge clk) begin
    datar <= rom_re[rom_addr];
    datai <= rom_im[rom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst_in_ready",    32'(in_ready),    32'd0);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_last",    32'(out_last),    32'd0);
    check("rst_out_re",      32'(out_re),      32'd0);
    check("rst_out_im",      32'(out_im),      32'd0);
    check("rst_out_idx",     32'(out_idx),     32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_frames_done", 32'(frames_done), 32'd0);
    check("rst_overrun",     32'(overrun),     32'd0);
    check("rst_rom_addr",    32'(rom_addr),    32'hC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; cfg_bypass = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic byp);
    @(negedge clk);
    start = 1'b1; cfg_bypass = byp; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic drive_sample(input int j, input logic byp);
    logic [3:0]  e_addr;
    logic [15:0] e_tr, e_ti, e_re, e_im;
    e_addr = byp ? 4'hC     : vecs[j].addr;
    e_tr   = byp ? 16'h7FFF : vecs[j].tw_re;
    e_ti   = byp ? 16'h0000 : vecs[j].tw_im;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    in_re = 16'hA000 | 16'(j);
    in_im = ~in_re;
    e_re = in_re; e_im = in_im;
    #1;
    check("in_ready", 32'(in_ready), 32'd1);
    check("rom_addr", 32'(rom_addr), 32'(e_addr));
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_idx",   32'(out_idx),   32'(j));
    check("out_re",    32'(out_re),    32'(e_re));
    check("out_im",    32'(out_im),    32'(e_im));
    check("out_last",  32'(out_last),  32'(j == 15));
    check("datar",     32'(datar),     32'(e_tr));
    check("datai",     32'(datai),     32'(e_ti));
  endtask

  task automatic finish_frame(input int exp_frames);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("drain_busy",     32'(busy),     32'd1);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("end_out_valid",   32'(out_valid),   32'd0);
    check("end_busy",        32'(busy),        32'd0);
    check("end_out_last",    32'(out_last),    32'd0);
    check("end_frames_done", 32'(frames_done), 32'(exp_frames));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   m_acc, m_idx, cyc;
    logic m_ov, m_done, acc, pop, exp_rdy;
    logic [15:0] m_re, m_im;

    vecs = '{
      '{4'hC, 16'h7FFF, 16'h0000}, '{4'hD, 16'h7FFF, 16'h0000},
      '{4'hE, 16'h7FFF, 16'h0000}, '{4'hF, 16'h7FFF, 16'h0000},
      '{4'h4, 16'h7FFF, 16'h0000}, '{4'h5, 16'h7641, 16'hCF05},
      '{4'h6, 16'h5A82, 16'hA57E}, '{4'h7, 16'h30FB, 16'h89BF},
      '{4'h0, 16'h7FFF, 16'h0000}, '{4'h1, 16'h5A82, 16'hA57E},
      '{4'h2, 16'h0000, 16'h8001}, '{4'h3, 16'hA57E, 16'hA57E},
      '{4'h8, 16'h7FFF, 16'h0000}, '{4'h9, 16'h30FB, 16'h89BF},
      '{4'hA, 16'hA57E, 16'hA57E}, '{4'hB, 16'h89BF, 16'h30FB}
    };
    for (int j = 0; j < 16; j++) begin
      rom_re[vecs[j].addr] = vecs[j].tw_re;
      rom_im[vecs[j].addr] = vecs[j].tw_im;
    end

    // Reset, then in_valid while idle must not be accepted.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Full-rate frame through the address table.
    pulse_start(1'b0);
    for (int j = 0; j < 16; j++) drive_sample(j, 1'b0);
    finish_frame(1);

    // Back-pressure at j=5 for three clocks.
    pulse_start(1'b0);
    for (int j = 0; j < 6; j++) drive_sample(j, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      #1;
      check("stall_rom_addr", 32'(rom_addr), 32'h5);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_idx",   32'(out_idx),   32'd5);
      check("stall_datar",     32'(datar),     32'h7641);
      check("stall_datai",     32'(datai),     32'hCF05);
    end
    for (int j = 6; j < 16; j++) drive_sample(j, 1'b0);
    finish_frame(2);

    // Bypass frame: unity twiddle everywhere.
    pulse_start(1'b1);
    for (int j = 0; j < 16; j++) drive_sample(j, 1'b1);
    finish_frame(3);

    // Stray start mid-frame.
    pulse_start(1'b0);
    check("pre_overrun", 32'(overrun), 32'd0);
    for (int j = 0; j < 7; j++) drive_sample(j, 1'b0);
    start = 1'b1;
    drive_sample(7, 1'b0);
    start = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    for (int j = 8; j < 16; j++) drive_sample(j, 1'b0);
    finish_frame(4);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame at j=9.
    pulse_start(1'b0);
    for (int j = 0; j < 9; j++) drive_sample(j, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    pulse_start(1'b0);
    for (int j = 0; j < 16; j++) drive_sample(j, 1'b0);
    finish_frame(1);

    // Random valid/ready over 1000 frames against a cycle model.
    do_reset();
    for (int f = 0; f < 1000 && n_fail < 20; f++) begin
      pulse_start(1'b0);
      m_acc = 0; m_idx = 0; m_ov = 1'b0; m_done = 1'b0; m_re = '0; m_im = '0;
      cyc = 0;
      while (!m_done && cyc < 400) begin
        cyc++;
        @(negedge clk);
        in_valid  = ($urandom_range(3, 0) != 0);
        out_ready = ($urandom_range(3, 0) != 0);
        in_re     = 16'($urandom);
        in_im     = 16'($urandom);
        #1;
        exp_rdy = (m_acc < 16) && (!m_ov || out_ready);
        check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = in_valid && exp_rdy;
        pop = m_ov && out_ready;
        if (acc) check("rnd_rom_addr", 32'(rom_addr), 32'(vecs[m_acc].addr));
        @(posedge clk);
        #1;
        if (pop && m_idx == 15) m_done = 1'b1;
        if (acc) begin
          m_ov = 1'b1; m_idx = m_acc; m_re = in_re; m_im = in_im; m_acc++;
        end else if (pop) begin
          m_ov = 1'b0;
        end
        check("rnd_out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
          check("rnd_out_idx",  32'(out_idx),  32'(m_idx));
          check("rnd_out_re",   32'(out_re),   32'(m_re));
          check("rnd_out_im",   32'(out_im),   32'(m_im));
          check("rnd_out_last", 32'(out_last), 32'(m_idx == 15));
          check("rnd_datar",    32'(datar),    32'(vecs[m_idx].tw_re));
          check("rnd_datai",    32'(datai),    32'(vecs[m_idx].tw_im));
        end
      end
      check("rnd_frame_complete", 32'(m_done), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rnd_frames_done", 32'(frames_done), 32'd1000);
    check("rnd_overrun",     32'(overrun),     32'd0);
    check("rnd_busy",        32'(busy),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
